spike_rate_encoder: RTL and testbench
=====================================

# spike_rate_encoder

Deterministic rate encoder that turns eight 8-bit input intensities into eight parallel spike trains. It is the input-side counterpart of the LIF network: its `spike_out` vector drives the network's per-neuron spike/current inputs, one spike vector per timestep. Intensities are loaded byte-serially over a valid/ready handshake. A run of `WINDOW` timesteps is then launched, and over a full 256-step window channel `i` emits exactly `intensity[i]` spikes.

## Interface
- `N_CH`, 8: number of channels; fixed at 8 for this revision.
- `WINDOW`, 256: timesteps per run; legal range 1..65535.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high; one clock, no other reset.
- `ena` input 1: timestep enable; each RUN cycle with `ena`=1 is one timestep.
- `load_valid` input 1: `load_data` is valid.
- `load_ready` output 1: encoder accepts a byte this cycle (combinational).
- `load_data` input 8: intensity byte, channels delivered in order 0..7.
- `start` input 1: single-cycle run request.
- `busy` output 1: high in RUN and DONE.
- `spike_out` output 8: registered spike vector, bit `i` = channel `i`.
- `step_valid` output 1: `spike_out` holds a new timestep this cycle.
- `done` output 1: one-cycle pulse that coincides with the last `step_valid` of a run.

## Operation
- Storage: `intensity[0..7]` (8 bit each), `acc[0..7]` (8 bit each), `wr_ptr` (3 bit), `step_cnt` (16 bit), and a state register. All clear to 0 on reset; state resets to IDLE.
- States:
  - IDLE: accepts loads and start.
  - RUN: generates timesteps.
  - DONE: one cycle, then returns to IDLE.
- Load:
  - `load_ready` = (state==IDLE) && !(start && wr_ptr==0).
  - On `load_valid && load_ready`, write `intensity[wr_ptr]` and increment `wr_ptr`, wrapping 7→0.
  - Loads are ignored outside IDLE.
- Start:
  - Accepted only in IDLE with `wr_ptr`==0. Start beats a same-cycle load; that byte is not consumed.
  - Start with `wr_ptr`≠0 (partial load) is ignored and has no effect.
  - On acceptance, all `acc` and `step_cnt` clear to 0 and the state moves to RUN.
  - Intensities persist across runs, so an identical run needs no reload.
- RUN timestep (`ena`=1):
  - Per channel, compute the 9-bit sum = `acc` + `intensity`.
  - `spike_out[i]` <= sum[8]; `acc` <= sum[7:0].
  - `step_valid` <= 1; `step_cnt` increments.
  - If `step_cnt`==WINDOW-1 at this step, go to DONE.
- RUN with `ena`=0: `acc` and `step_cnt` hold; `spike_out` <= 0; `step_valid` <= 0.
- DONE: lasts exactly one cycle, then IDLE. No `ena` dependence.
- Arithmetic:
  - With `acc` starting at 0, the first spike occurs at step ceil(256/I)-1 (0-based).
  - Intensity 0 never spikes; 255 spikes 255 of every 256 steps.
- Spikes are single-cycle pulses. `spike_out` is 0 whenever `step_valid` is 0.

## Timing
- Reset values:
  - `spike_out`=0, `step_valid`=0, `done`=0, `busy`=0.
  - `load_ready`=1 (IDLE, `wr_ptr`=0); loads are ignored while `rst` is high.
- Start latency: start accepted at cycle t gives `busy`=1 at t+1. The first timestep can occur at t+1 if `ena`=1.
- Step latency: a timestep taken at cycle t has its `spike_out`/`step_valid` visible during t+1.
- Run end:
  - The final step at cycle t gives state DONE, `done`=1, and `step_valid`=1 at t+1 (final spikes visible).
  - IDLE at t+2, with `busy`=0 and `load_ready`=1.
- Minimum run length with `ena` tied high: WINDOW+2 cycles from start to IDLE.
- Reset mid-operation:
  - All outputs and state clear immediately, asynchronously.
  - Intensities clear to 0 and any partial load is lost.
- `start` during RUN or DONE is ignored and is not queued.

## Test plan
- Reset: assert `rst` mid-cycle → outputs go to 0 without waiting for a clock edge, `load_ready`=1, `busy`=0.
- Full run:
  - Load {0,1,64,128,200,255,32,7}, start, `ena`=1, WINDOW=256.
  - Per-channel spike counts are {0,1,64,128,200,255,32,7}.
  - Channel 3 spikes on odd steps only; channel 1 spikes only at step 255.
  - `done` coincides with the 256th `step_valid`.
- Gated `ena`: same load with `ena` toggling every cycle → identical spike sequence per step; `step_valid` only in cycles after `ena`=1; run takes ≈2×256 cycles.
- Handshake edges:
  - Start after 3 of 8 bytes → ignored, `busy` stays 0.
  - Finish the load, then assert start and `load_valid` together → start accepted, `load_ready`=0 that cycle, byte not written.
- Reset mid-RUN: assert `rst` at step 100 → all outputs 0 at once. Start without reload → 256 steps with no spikes; `done` still pulses.
- Repeat run: two back-to-back runs without reload, WINDOW=16, intensity 100 → identical spike patterns both runs (steps 2,5,7,10,12,15 for ch 0), since `acc` is cleared at start.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - eight-channel deterministic rate encoder driven by per-channel accumulators
module spike_rate_encoder #(
    parameter int N_CH   = 8,
    parameter int WINDOW = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [7:0]      load_data,
    input  logic            start,
    output logic            busy,
    output logic [N_CH-1:0] spike_out,
    output logic            step_valid,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_STEP = 16'(WINDOW - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  intensity [N_CH];
    logic [7:0]  acc       [N_CH];
    logic [2:0]  wr_ptr;
    logic [15:0] step_cnt;
    logic        start_ok;
    logic        load_fire;
    logic        step_take;

    // A start with an empty write pointer wins over a same-cycle byte, which stays unconsumed.
    assign start_ok   = (state == S_IDLE) && start && (wr_ptr == 3'd0);
    assign load_ready = (state == S_IDLE) && !(start && (wr_ptr == 3'd0));
    assign load_fire  = load_valid && load_ready;
    assign step_take  = (state == S_RUN) && ena;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_RUN;
            S_RUN:  if (step_take && (step_cnt == LAST_STEP)) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                intensity[i] <= 8'd0;
                acc[i]       <= 8'd0;
            end
            wr_ptr     <= 3'd0;
            step_cnt   <= 16'd0;
            spike_out  <= '0;
            step_valid <= 1'b0;
        end else begin
            spike_out  <= '0;
            step_valid <= 1'b0;
            if (load_fire) begin
                intensity[wr_ptr] <= load_data;
                wr_ptr            <= wr_ptr + 3'd1;
            end
            if (start_ok) begin
                for (int i = 0; i < N_CH; i++) begin
                    acc[i] <= 8'd0;
                end
                step_cnt <= 16'd0;
            end
            // The carry out of each 8-bit accumulator is that channel's spike.
            if (step_take) begin
                for (int i = 0; i < N_CH; i++) begin
                    {spike_out[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, intensity[i]};
                end
                step_valid <= 1'b1;
                step_cnt   <= step_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - scoreboard bench for spike_rate_encoder
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;

    logic       a_load_valid, a_load_ready, a_start, a_busy, a_step_valid, a_done;
    logic [7:0] a_load_data, a_spike_out;
    logic       b_load_valid, b_load_ready, b_start, b_busy, b_step_valid, b_done;
    logic [7:0] b_load_data, b_spike_out;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] qa [$];
    logic [8:0] qb [$];
    logic [7:0] m_int [8];
    logic [7:0] a_obs [256];
    int         a_idx = 0;
    logic       ena_q = 1'b0;
    int         cyc;

    always #5 clk = ~clk;

    spike_rate_encoder #(.N_CH(8), .WINDOW(256)) u_dut_a (
        .clk(clk), .rst(rst), .ena(ena),
        .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
        .start(a_start), .busy(a_busy), .spike_out(a_spike_out),
        .step_valid(a_step_valid), .done(a_done)
    );

    spike_rate_encoder #(.N_CH(8), .WINDOW(16)) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena),
        .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
        .start(b_start), .busy(b_busy), .spike_out(b_spike_out),
        .step_valid(b_step_valid), .done(b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model_a();
        logic [7:0] acc_m [8];
        logic [8:0] s;
        logic [7:0] v;
        for (int c = 0; c < 8; c++) acc_m[c] = 8'd0;
        for (int k = 0; k < 256; k++) begin
            v = 8'd0;
            for (int c = 0; c < 8; c++) begin
                s        = {1'b0, acc_m[c]} + {1'b0, m_int[c]};
                v[c]     = s[8];
                acc_m[c] = s[7:0];
            end
            qa.push_back({(k == 255), v});
        end
    endtask

    task automatic push_hand_b();
        int sp [6];
        logic [7:0] v;
        sp = '{2, 5, 7, 10, 12, 15};
        for (int k = 0; k < 16; k++) begin
            v = 8'd0;
            for (int j = 0; j < 6; j++) if (sp[j] == k) v[0] = 1'b1;
            qb.push_back({(k == 15), v});
        end
    endtask

    task automatic a_load_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            a_load_valid = 1'b1;
            a_load_data  = m_int[i];
            tick();
        end
        a_load_valid = 1'b0;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic run_a(input bit gated, input bit inject, output int n);
        n = 0;
        forever begin
            a_start = (inject && n == 50);
            tick();
            n++;
            if (gated) ena = ~ena;
            if (a_done) break;
            if (n >= 2000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_run_timeout: got no done after %0d cycles, expected done", n);
                break;
            end
        end
        a_start = 1'b0;
    endtask

    task automatic run_b(output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (b_done) break;
            if (n >= 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_run_timeout: got no done after %0d cycles, expected done", n);
                break;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        ena_q = ena;
    end

    initial begin : mon_a
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_idx = 0;
            end else if (a_step_valid) begin
                check("a_step_after_ena", 32'(ena_q), 32'd1);
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL a_unexpected_step: got spikes %0h, expected no step", a_spike_out);
                end else begin
                    e = qa.pop_front();
                    check("a_step", 32'({a_done, a_spike_out}), 32'(e));
                end
                if (a_idx < 256) a_obs[a_idx] = a_spike_out;
                a_idx = a_done ? 0 : a_idx + 1;
            end else begin
                check("a_quiet", 32'({a_done, a_spike_out}), 32'd0);
            end
        end
    end

    initial begin : mon_b
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b_step_valid) begin
                    if (qb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL b_unexpected_step: got spikes %0h, expected no step", b_spike_out);
                    end else begin
                        e = qb.pop_front();
                        check("b_step", 32'({b_done, b_spike_out}), 32'(e));
                    end
                end else begin
                    check("b_quiet", 32'({b_done, b_spike_out}), 32'd0);
                end
            end
        end
    end

    initial begin
        int  exp_cnt [8];
        int  cnt;
        bit  ok;
        exp_cnt = '{0, 1, 64, 128, 200, 255, 32, 7};

        rst = 1'b1;
        ena = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        a_load_valid = 1'b1;
        a_load_data  = 8'h55;
        b_load_valid = 1'b0;
        b_load_data  = 8'h00;
        #12;
        check("rst_spike", 32'(a_spike_out), 32'd0);
        check("rst_step_valid", 32'(a_step_valid), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_load_ready", 32'(a_load_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_load_valid = 1'b0;

        // Full run with ena high and a start pulse injected mid-run
        m_int = '{8'd0, 8'd1, 8'd64, 8'd128, 8'd200, 8'd255, 8'd32, 8'd7};
        a_load_range(0, 7);
        ena = 1'b1;
        push_model_a();
        a_start_pulse();
        check("start_busy", 32'(a_busy), 32'd1);
        run_a(1'b0, 1'b1, cyc);
        check("full_run_cycles", 32'(cyc), 32'd256);
        tick();
        check("end_busy", 32'(a_busy), 32'd0);
        check("end_load_ready", 32'(a_load_ready), 32'd1);
        for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int k = 0; k < 256; k++) cnt += int'(a_obs[k][c]);
            check($sformatf("ch%0d_count", c), 32'(cnt), 32'(exp_cnt[c]));
        end
        ok = 1'b1;
        for (int k = 0; k < 256; k++) if (a_obs[k][1] != (k == 255)) ok = 1'b0;
        check("ch1_only_last", 32'(ok), 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 256; k++) if (a_obs[k][3] != k[0]) ok = 1'b0;
        check("ch3_odd_steps", 32'(ok), 32'd1);

        // Gated ena, no reload
        push_model_a();
        ena = 1'b0;
        a_start_pulse();
        ena = 1'b1;
        run_a(1'b1, 1'b0, cyc);
        check("gated_run_cycles", 32'(cyc), 32'd511);
        ena = 1'b1;
        tick();
        check("gated_end_busy", 32'(a_busy), 32'd0);

        // Partial-load start ignored, then start beats a same-cycle byte
        a_load_range(0, 2);
        a_start_pulse();
        check("partial_start_ignored", 32'(a_busy), 32'd0);
        a_load_range(3, 7);
        a_start = 1'b1;
        a_load_valid = 1'b1;
        a_load_data = 8'hAA;
        #1;
        check("start_blocks_load", 32'(a_load_ready), 32'd0);
        push_model_a();
        tick();
        a_start = 1'b0;
        a_load_valid = 1'b0;
        check("start_with_load_busy", 32'(a_busy), 32'd1);
        run_a(1'b0, 1'b0, cyc);
        check("handshake_run_cycles", 32'(cyc), 32'd256);
        tick();

        // Reset at step 100, then a reload-free run must be silent
        push_model_a();
        a_start_pulse();
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b1;
        qa.delete();
        #1;
        check("midrst_spike", 32'(a_spike_out), 32'd0);
        check("midrst_step_valid", 32'(a_step_valid), 32'd0);
        check("midrst_done", 32'(a_done), 32'd0);
        check("midrst_busy", 32'(a_busy), 32'd0);
        check("midrst_load_ready", 32'(a_load_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) m_int[c] = 8'd0;
        push_model_a();
        a_start_pulse();
        run_a(1'b0, 1'b0, cyc);
        check("zero_run_cycles", 32'(cyc), 32'd256);
        tick();

        // Two back-to-back 16-step runs, intensity 100 on channel 0
        for (int i = 0; i < 8; i++) begin
            b_load_valid = 1'b1;
            b_load_data  = (i == 0) ? 8'd100 : 8'd0;
            tick();
        end
        b_load_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_hand_b();
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            run_b(cyc);
            check($sformatf("b_run%0d_cycles", r), 32'(cyc), 32'd16);
            tick();
        end

        repeat (3) tick();
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
